// File: rtl/reg_file_wb.sv
// 16 x 8 register file with ALU/load writeback arbitration,
// write-through read bypass and a per-register load scoreboard.
module reg_file_wb #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned PCT_IDX  = 1,
  parameter int unsigned LSB_IDX  = 2,
  parameter int unsigned MSB_IDX  = 3,
  parameter int unsigned PTN_IDX  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          rd_addr,
  output logic [DATA_W-1:0]   rf_reg_out,
  output logic [DATA_W-1:0]   rpct,
  output logic [DATA_W-1:0]   rlsb,
  output logic [DATA_W-1:0]   rmsb,
  output logic [DATA_W-1:0]   rptn,
  input  logic                wb_en,
  input  logic [3:0]          wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                ld_issue,
  input  logic [3:0]          ld_issue_addr,
  input  logic                ld_valid,
  input  logic [3:0]          ld_addr,
  input  logic [DATA_W-1:0]   ld_data,
  output logic                ld_ready,
  output logic                rd_busy,
  output logic                issue_stall,
  output logic [NUM_REGS-1:0] sb_pending
);

  localparam logic [3:0] PCT_A = 4'(PCT_IDX);
  localparam logic [3:0] LSB_A = 4'(LSB_IDX);
  localparam logic [3:0] MSB_A = 4'(MSB_IDX);
  localparam logic [3:0] PTN_A = 4'(PTN_IDX);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] sb_q;
  logic [NUM_REGS-1:0] sb_d;
  logic                ld_fire;

  assign ld_ready = ~wb_en;
  assign ld_fire  = ld_valid & ld_ready;

  // Only one write per cycle, so the next-state array doubles as the bypass view.
  always_comb begin
    regs_d = regs_q;
    if (wb_en) begin
      regs_d[wb_addr] = wb_data;
    end else if (ld_fire) begin
      regs_d[ld_addr] = ld_data;
    end
  end

  always_comb begin
    sb_d = sb_q;
    if (ld_fire) begin
      sb_d[ld_addr] = 1'b0;
    end
    if (ld_issue) begin
      sb_d[ld_issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
      sb_q <= '0;
    end else begin
      regs_q <= regs_d;
      sb_q   <= sb_d;
    end
  end

  assign rf_reg_out = reset ? '0 : regs_d[rd_addr];
  assign rpct       = reset ? '0 : regs_d[PCT_A];
  assign rlsb       = reset ? '0 : regs_d[LSB_A];
  assign rmsb       = reset ? '0 : regs_d[MSB_A];
  assign rptn       = reset ? '0 : regs_d[PTN_A];

  assign sb_pending  = sb_q;
  assign issue_stall = sb_q[ld_issue_addr];
  assign rd_busy     = sb_q[rd_addr] &
                       ~(ld_fire & (ld_addr == rd_addr));

endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: directed plan then random traffic,
// checked against an array-level model of the register file.
module tb_reg_file_wb;

  typedef struct packed {
    logic [7:0]  rf;
    logic [7:0]  pct;
    logic [7:0]  lsb;
    logic [7:0]  msb;
    logic [7:0]  ptn;
    logic        rdy;
    logic        busy;
    logic        stall;
    logic [15:0] sb;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rd_addr = '0;
  logic [7:0]  rf_reg_out, rpct, rlsb, rmsb, rptn;
  logic        wb_en = 1'b1;
  logic [3:0]  wb_addr = 4'd2;
  logic [7:0]  wb_data = 8'hAA;
  logic        ld_issue = 1'b0;
  logic [3:0]  ld_issue_addr = '0;
  logic        ld_valid = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic        ld_ready, rd_busy, issue_stall;
  logic [15:0] sb_pending;

  int total = 0;
  int bad = 0;

  obs_t  exp_q[$];
  string tag_q[$];

  logic [7:0] mem [16];
  bit         pend [16];

  reg_file_wb dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr),
    .rf_reg_out(rf_reg_out), .rpct(rpct), .rlsb(rlsb),
    .rmsb(rmsb), .rptn(rptn), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .ld_issue(ld_issue), .ld_issue_addr(ld_issue_addr),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready), .rd_busy(rd_busy),
    .issue_stall(issue_stall), .sb_pending(sb_pending)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_rd(input int x);
    if (reset) return 8'h00;
    if (wb_en && int'(wb_addr) == x) return wb_data;
    if (ld_valid && !wb_en && int'(ld_addr) == x) return ld_data;
    return mem[x];
  endfunction

  task automatic step(input string tag, input logic rst,
                      input logic we, input logic [3:0] wa,
                      input logic [7:0] wd, input logic li,
                      input logic [3:0] lia, input logic lv,
                      input logic [3:0] la, input logic [7:0] ldd,
                      input logic [3:0] ra);
    obs_t e;
    bit   fire;
    @(posedge clk);
    #1;
    reset = rst; wb_en = we; wb_addr = wa; wb_data = wd;
    ld_issue = li; ld_issue_addr = lia;
    ld_valid = lv; ld_addr = la; ld_data = ldd; rd_addr = ra;
    fire = lv && !we;
    e.rf  = model_rd(int'(ra));
    e.pct = model_rd(1);
    e.lsb = model_rd(2);
    e.msb = model_rd(3);
    e.ptn = model_rd(4);
    e.rdy = !we;
    e.sb = '0;
    for (int i = 0; i < 16; i++) e.sb[i] = rst ? 1'b0 : pend[i];
    e.stall = e.sb[lia];
    e.busy = e.sb[ra] && !(fire && la == ra);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] = 8'h00;
        pend[i] = 1'b0;
      end
    end else begin
      if (we) mem[wa] = wd;
      else if (fire) mem[la] = ldd;
      if (fire) pend[la] = 1'b0;
      if (li) pend[lia] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  e;
      obs_t  a;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {rf_reg_out, rpct, rlsb, rmsb, rptn,
           ld_ready, rd_busy, issue_stall, sb_pending};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got %h want %h", t, a, e);
      end
    end
  end

  initial begin
    bit         hold;
    logic       we, li, lv, rs;
    logic [3:0] wa, lia, la, ra;
    logic [7:0] wd, ldd;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'h00;
      pend[i] = 1'b0;
    end
    step("rst_a", 1, 1, 2, 8'hAA, 0, 0, 0, 0, 0, 2);
    step("rst_b", 1, 1, 2, 8'hAA, 0, 0, 0, 0, 0, 2);
    step("rel_lsb", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    step("wr_byp", 0, 1, 1, 8'h5C, 0, 0, 0, 0, 0, 1);
    step("wr_keep", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("arb_wb", 0, 1, 3, 8'h11, 0, 0, 1, 3, 8'h22, 0);
    step("arb_ld", 0, 0, 0, 0, 0, 0, 1, 3, 8'h22, 0);
    step("arb_aft", 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    step("sb_iss", 0, 0, 0, 0, 1, 4, 0, 0, 0, 0);
    step("sb_busy", 0, 0, 0, 0, 1, 4, 0, 0, 0, 4);
    step("sb_ret", 0, 0, 0, 0, 0, 0, 1, 4, 8'h9F, 4);
    step("sb_clr", 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    step("col_iss", 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    step("col", 0, 0, 0, 0, 1, 5, 1, 5, 8'h77, 5);
    step("col_aft", 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    step("mid_iss", 0, 0, 0, 0, 1, 4, 0, 0, 0, 0);
    step("mid_pend", 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    step("mid_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    step("mid_rel", 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    step("late_ret", 0, 0, 0, 0, 0, 0, 1, 5, 8'hC3, 5);
    step("late_aft", 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);

    hold = 1'b0;
    la = '0; ldd = '0; lv = 1'b0;
    for (int n = 0; n < 400; n++) begin
      rs  = ($urandom_range(0, 99) < 2);
      we  = ($urandom_range(0, 99) < 35);
      wa  = 4'($urandom_range(0, 15));
      wd  = 8'($urandom);
      li  = ($urandom_range(0, 99) < 25);
      lia = 4'($urandom_range(0, 15));
      ra  = 4'($urandom_range(0, 15));
      if (!hold) begin
        lv  = ($urandom_range(0, 99) < 45);
        la  = 4'($urandom_range(0, 15));
        ldd = 8'($urandom);
      end
      step("rand", rs, we, wa, wd, li, lia, lv, la, ldd, ra);
      hold = lv && we;
    end

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
